fib_pair_serializer: RTL and testbench
======================================

# fib_pair_serializer

Downstream consumer for the double-rate Fibonacci generator. It accepts two consecutive sequence values per transfer, buffers them in a small FIFO, and emits one value per cycle on a valid/ready stream, so the double-rate source can feed single-rate sinks. It also flags 16-bit arithmetic wrap-around in the incoming sequence and counts emitted values.

## Interface
- `W`, default 16: data width of each sequence value.
- `DEPTH`, default 8: FIFO depth in values. Must be a power of 2 and at least 4.
- `clk` in, 1: the single clock; all state changes on posedge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: an input pair is presented.
- `in_ready` out, 1: the block can accept a pair this cycle.
- `in_lo` in, W: earlier value of the pair (sequence index n).
- `in_hi` in, W: later value of the pair (index n+1).
- `out_valid` out, 1: `out_data` holds a buffered value.
- `out_ready` in, 1: the sink accepts `out_data` this cycle.
- `out_data` out, W: head of the FIFO.
- `wrap_flag` out, 1: sticky flag; a decrease was detected in the sequence.
- `out_count` out, 32: number of values emitted since reset.

## Operation
- Push:
  - A pair is accepted when `in_valid && in_ready` at a posedge.
  - `in_lo` is written first, then `in_hi`, so `in_lo` is popped first.
- `in_ready` is 1 iff free slots ≥ 2.
  - Free slots = DEPTH − occupancy, using registered occupancy only.
  - There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- Pop:
  - `out_valid` = (occupancy ≠ 0).
  - A value is popped when `out_valid && out_ready`.
- `out_data` = FIFO head when `out_valid` = 1, else 0.
- Simultaneous push and pop in one cycle: occupancy changes by +2 − 1 = +1.
  - `in_ready` for that cycle is still evaluated on the pre-pop occupancy.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is held in a separate log2(DEPTH)+1-bit counter (0..DEPTH).
- Wrap detection, on each accepted pair:
  - Set `wrap_flag` if `in_hi < in_lo` (unsigned).
  - Set `wrap_flag` if `last_hi` is valid and `in_lo < last_hi`.
  - `last_hi` is a register holding `in_hi` of the previous accepted pair. It is invalid until the first push after reset.
  - Equal values do not set the flag (the sequence starts 1,1).
  - Once set, `wrap_flag` stays 1 until `rst`. Data still passes through unchanged.
- `out_count` increments by 1 per pop and wraps modulo 2^32.
- `in_valid` with `in_ready` = 0: no state change. The source must hold the pair.

## Timing
- Reset values (asynchronous): `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `wrap_flag` = 0, `out_count` = 0.
  - Also reset: occupancy, both pointers, and the `last_hi` valid bit.
  - FIFO storage is not reset.
- Latency:
  - A pair accepted at edge N makes `in_lo` visible on `out_data` with `out_valid` = 1 in the cycle after edge N.
  - `in_hi` becomes the head after `in_lo` pops.
- Throughput:
  - The output side sustains 1 value per cycle.
  - The input side sustains 1 pair per 2 cycles in steady state with `out_ready` held at 1.
- `wrap_flag` rises in the cycle after the edge that accepted the offending pair.
- Reset mid-operation: all buffered values are discarded immediately. `out_valid` drops asynchronously with `rst`.

## Structure
- Package `fib_pkg`:
  - `FIB_W = 16`
  - typedef `fib_t` (logic [FIB_W-1:0])
  - typedef `fib_pair_t` (struct: `lo`, `hi`)
- Sub-module `fib_pair_fifo`:
  - 2-write, 1-read FIFO holding storage, pointers and occupancy.
  - Exposes `free_ge2` and `not_empty`.
- The top level adds the wrap detector, `last_hi`, and `out_count`.

## Test plan
- Streaming with `out_ready` = 1: push (1,1), (2,3), (5,8) whenever `in_ready` = 1 → `out_data` = 1,1,2,3,5,8 on consecutive valid cycles; `out_count` = 6; `wrap_flag` = 0.
- Fill: `out_ready` = 0, `in_valid` = 1 with DEPTH = 8 → 4 pairs accepted, then `in_ready` = 0. A 5th pair (89,144) is held until `out_ready` = 1; it is accepted only after two pops.
- Simultaneous push/pop at occupancy 6, both handshakes in one cycle → occupancy 7 and `in_ready` = 0 next cycle; values are output in order with no loss.
- In-pair wrap: push (46368, 9489) → `wrap_flag` = 1 next cycle and stays 1 through later valid pairs; 46368 and 9489 are still output.
- Cross-pair wrap: push (17711, 28657), then (9489, 38146) → `wrap_flag` = 1 after the second push only. Equal pair (1,1) after reset → flag stays 0.
- Reset mid-stream: assert `rst` with 5 values buffered → `out_valid` = 0 immediately, `in_ready` = 1, `out_count` = 0. After release, the first pushed pair is output first.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared widths and types for the Fibonacci pair datapath.
package fib_pkg;

  localparam int FIB_W = 16;

  typedef logic [FIB_W-1:0] fib_t;

  typedef struct packed {
    fib_t hi;
    fib_t lo;
  } fib_pair_t;

  // Unsigned "sequence went backwards" test; equal values are legal (1,1).
  function automatic logic fib_decreased(input fib_t prev, input fib_t cur);
    return cur < prev;
  endfunction

endpackage

// File: rtl/fib_pair_fifo.sv
// Two-write, one-read FIFO: a pair is written in one cycle, values leave one at a time.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_lo,
  input  logic [W-1:0] push_hi,
  input  logic         pop,
  output logic         free_ge2,
  output logic         not_empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - 2);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_plus1;
  logic [AW:0]   occ_reg, occ_next;
  logic [DEPTH-1:0] slot_we;
  logic [W-1:0]  slot_wd [DEPTH];

  assign wr_ptr_plus1 = wr_ptr_reg + AW'(1);

  // Each slot decodes whether it receives the lo or hi half of this push.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_we[gi] = push && ((wr_ptr_reg == AW'(gi)) || (wr_ptr_plus1 == AW'(gi)));
      assign slot_wd[gi] = (wr_ptr_reg == AW'(gi)) ? push_lo : push_hi;
    end
  endgenerate

  // Storage carries no reset so it can map onto plain distributed memory.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        mem_reg[i] <= slot_wd[i];
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(2);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + (AW+1)'(2);
      2'b11:   occ_next = occ_reg + (AW+1)'(1);
      2'b01:   occ_next = occ_reg - (AW+1)'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Flags come only from registered occupancy, keeping in_ready free of out_ready.
  assign free_ge2  = (occ_reg <= READY_LIMIT);
  assign not_empty = (occ_reg != '0);
  assign head      = not_empty ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/fib_pair_serializer.sv
// Serializes Fibonacci pairs to one value per cycle, flags wrap-around and counts output.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_lo,
  input  logic [W-1:0] in_hi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         wrap_flag,
  output logic [31:0]  out_count
);

  logic         push, pop;
  logic         free_ge2, not_empty;
  logic [W-1:0] last_hi_reg, last_hi_next;
  logic         last_hi_valid_reg, last_hi_valid_next;
  logic         wrap_flag_reg, wrap_flag_next;
  logic [31:0]  out_count_reg, out_count_next;

  assign in_ready  = free_ge2;
  assign out_valid = not_empty;
  assign push      = in_valid && free_ge2;
  assign pop       = not_empty && out_ready;

  fib_pair_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_lo   (in_lo),
    .push_hi   (in_hi),
    .pop       (pop),
    .free_ge2  (free_ge2),
    .not_empty (not_empty),
    .head      (out_data)
  );

  always_comb begin
    last_hi_next       = last_hi_reg;
    last_hi_valid_next = last_hi_valid_reg;
    wrap_flag_next     = wrap_flag_reg;
    out_count_next     = out_count_reg;
    if (push) begin
      last_hi_next       = in_hi;
      last_hi_valid_next = 1'b1;
      if (in_hi < in_lo) begin
        wrap_flag_next = 1'b1;
      end
      if (last_hi_valid_reg && (in_lo < last_hi_reg)) begin
        wrap_flag_next = 1'b1;
      end
    end
    if (pop) begin
      out_count_next = out_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_hi_reg       <= '0;
      last_hi_valid_reg <= 1'b0;
      wrap_flag_reg     <= 1'b0;
      out_count_reg     <= '0;
    end else begin
      last_hi_reg       <= last_hi_next;
      last_hi_valid_reg <= last_hi_valid_next;
      wrap_flag_reg     <= wrap_flag_next;
      out_count_reg     <= out_count_next;
    end
  end

  assign wrap_flag = wrap_flag_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed bench for fib_pair_serializer with an ordering scoreboard.
module tb_fib_pair_serializer;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_lo = '0;
  logic [W-1:0]  in_hi = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          wrap_flag;
  logic [31:0]   out_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  fib_pair_serializer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .wrap_flag (wrap_flag),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle; inputs are already set, called 1 time unit after an edge.
  task automatic cyc(output bit accepted);
    logic [W-1:0] want;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() <= DEPTH - 2));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(want));
        $display("[TB] pop  data=%0d", out_data);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(in_lo);
      exp_q.push_back(in_hi);
      $display("[TB] push lo=%0d hi=%0d", in_lo, in_hi);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_wrap", 32'(wrap_flag), 32'd0);
    check("rst_count", out_count, 32'd0);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Present one pair until accepted, bounded.
  task automatic push_pair(input logic [W-1:0] lo, input logic [W-1:0] hi);
    bit acc;
    int guard;
    in_lo = lo;
    in_hi = hi;
    in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 40) begin
      cyc(acc);
      guard++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int guard;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      cyc(acc);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    check("drained_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit acc;
    int pops_seen;
    logic [W-1:0] lo_tab [3];
    logic [W-1:0] hi_tab [3];
    lo_tab = '{16'd1, 16'd2, 16'd5};
    hi_tab = '{16'd1, 16'd3, 16'd8};

    // Streaming with sink always ready.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_pair(lo_tab[i], hi_tab[i]);
    drain();
    check("stream_count", out_count, 32'd6);
    check("stream_wrap", 32'(wrap_flag), 32'd0);

    // Fill to DEPTH, hold the fifth pair until two pops free space.
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd3);
    push_pair(16'd5, 16'd8);
    push_pair(16'd13, 16'd21);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_lo = 16'd89;
    in_hi = 16'd144;
    in_valid = 1'b1;
    cyc(acc);
    cyc(acc);
    check("full_held", 32'(acc), 32'd0);
    check("full_no_count", out_count, 32'd0);
    out_ready = 1'b1;
    pops_seen = 0;
    acc = 1'b0;
    while (!acc && pops_seen < 6) begin
      cyc(acc);
      pops_seen++;
    end
    in_valid = 1'b0;
    check("accept_after_pops", 32'(pops_seen), 32'd3);
    check("simul_in_ready", 32'(in_ready), 32'd0);
    check("simul_out_count", out_count, 32'd3);
    drain();
    check("fill_count", out_count, 32'd10);

    // In-pair wrap stays sticky across later good pairs.
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd46368, 16'd9489);
    check("inpair_wrap", 32'(wrap_flag), 32'd1);
    push_pair(16'd10000, 16'd20000);
    drain();
    check("inpair_sticky", 32'(wrap_flag), 32'd1);
    check("inpair_count", out_count, 32'd4);

    // Cross-pair wrap.
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd17711, 16'd28657);
    check("cross_first", 32'(wrap_flag), 32'd0);
    push_pair(16'd9489, 16'd38146);
    check("cross_second", 32'(wrap_flag), 32'd1);
    drain();

    // Equal values never flag.
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    push_pair(16'd1, 16'd2);
    drain();
    check("equal_no_wrap", 32'(wrap_flag), 32'd0);

    // Asynchronous reset with five values buffered.
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd3);
    push_pair(16'd5, 16'd8);
    out_ready = 1'b1;
    cyc(acc);
    out_ready = 1'b0;
    check("pre_rst_count", out_count, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_count", out_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    push_pair(16'd7, 16'd9);
    check("post_rst_head", 32'(out_data), 32'd7);
    drain();
    check("post_rst_count", out_count, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
